// File: rtl/fill_readout_sequencer.sv
// fill_readout_sequencer
// Pops one fill number from the trigger manager, emits a header word, walks
// every enabled digitizer channel through a start/done readout handshake in
// ascending order with a per-channel timeout, then emits a trailer word that
// reports which channels completed and which timed out.
//
// Ports:
//   clk          single rising-edge clock
//   reset_n      asynchronous active-low reset (released synchronously to clk)
//   chan_enable  channel mask, captured when a fill is accepted
//   fill_valid   fill number available from the trigger manager FIFO
//   fill_num     fill number
//   fill_ready   pop strobe towards the fill-number FIFO (high only in IDLE)
//   evt_valid    header/trailer word valid towards the event builder
//   evt_data     header {F1, fill_num} or trailer {F2, tmo_mask, rd_mask}
//   evt_ready    event builder accept
//   rd_start     one-cycle readout start pulse
//   rd_chan      channel currently being read
//   rd_done      channel readout complete (only looked at while waiting)
//   busy         high whenever a fill is in progress
//   timeout_err  one-cycle pulse on the last wait cycle of a timed-out channel
module fill_readout_sequencer #(
  parameter int NUM_CHAN  = 5,
  parameter int FILLNUM_W = 24,
  parameter int TIMEOUT   = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CHAN-1:0]  chan_enable,
  input  logic                 fill_valid,
  input  logic [FILLNUM_W-1:0] fill_num,
  output logic                 fill_ready,
  output logic                 evt_valid,
  output logic [31:0]          evt_data,
  input  logic                 evt_ready,
  output logic                 rd_start,
  output logic [2:0]           rd_chan,
  input  logic                 rd_done,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_SCAN,
    ST_START,
    ST_WAIT,
    ST_TRAILER
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [FILLNUM_W-1:0]   fill_num_q, fill_num_d;
  logic [NUM_CHAN-1:0]    pend_mask_q, pend_mask_d;
  logic [NUM_CHAN-1:0]    rd_mask_q, rd_mask_d;
  logic [NUM_CHAN-1:0]    tmo_mask_q, tmo_mask_d;
  logic [2:0]             rd_chan_q, rd_chan_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   fill_ready_q, fill_ready_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [31:0]            evt_data_q, evt_data_d;
  logic                   rd_start_q, rd_start_d;
  logic                   busy_q, busy_d;
  logic [2:0]             low_idx;

  // Lowest set bit of the pending mask: scanning from the top down lets the
  // last hit (the lowest index) win.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (pend_mask_q[i]) low_idx = 3'(i);
    end
  end

  // Next-state logic. timeout_err is decoded here rather than registered
  // because it must stay low when rd_done lands on the expiry cycle itself,
  // and that is only known during the cycle.
  always_comb begin
    state_d     = state_q;
    fill_num_d  = fill_num_q;
    pend_mask_d = pend_mask_q;
    rd_mask_d   = rd_mask_q;
    tmo_mask_d  = tmo_mask_q;
    rd_chan_d   = rd_chan_q;
    cnt_d       = cnt_q;
    timeout_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_valid) begin
          fill_num_d  = fill_num;
          pend_mask_d = chan_enable;
          rd_mask_d   = '0;
          tmo_mask_d  = '0;
          state_d     = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (evt_ready) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (pend_mask_q == '0) begin
          state_d = ST_TRAILER;
        end else begin
          rd_chan_d            = low_idx;
          pend_mask_d[low_idx] = 1'b0;
          state_d              = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_done) begin
          rd_mask_d[rd_chan_q] = 1'b1;
          state_d              = ST_SCAN;
        end else if (cnt_q == CNT_LAST) begin
          tmo_mask_d[rd_chan_q] = 1'b1;
          timeout_err           = 1'b1;
          state_d               = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_TRAILER: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe; the event word is built from the next-cycle
  // fill number and masks, which do not change while a word is held.
  always_comb begin
    fill_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    rd_start_d   = (state_d == ST_START);
    evt_valid_d  = (state_d == ST_HEADER) || (state_d == ST_TRAILER);
    evt_data_d   = '0;
    if (state_d == ST_HEADER) begin
      evt_data_d = {8'hF1, 24'(fill_num_d)};
    end else if (state_d == ST_TRAILER) begin
      evt_data_d = {8'hF2, 3'b000, 5'(tmo_mask_d), 11'b0, 5'(rd_mask_d)};
    end
  end

  // Single state register for the whole sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fill_num_q   <= '0;
      pend_mask_q  <= '0;
      rd_mask_q    <= '0;
      tmo_mask_q   <= '0;
      rd_chan_q    <= '0;
      cnt_q        <= '0;
      fill_ready_q <= 1'b1;
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      rd_start_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_num_q   <= fill_num_d;
      pend_mask_q  <= pend_mask_d;
      rd_mask_q    <= rd_mask_d;
      tmo_mask_q   <= tmo_mask_d;
      rd_chan_q    <= rd_chan_d;
      cnt_q        <= cnt_d;
      fill_ready_q <= fill_ready_d;
      evt_valid_q  <= evt_valid_d;
      evt_data_q   <= evt_data_d;
      rd_start_q   <= rd_start_d;
      busy_q       <= busy_d;
    end
  end

  assign fill_ready = fill_ready_q;
  assign evt_valid  = evt_valid_q;
  assign evt_data   = evt_data_q;
  assign rd_start   = rd_start_q;
  assign rd_chan    = rd_chan_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fill_readout_sequencer.sv
// tb_fill_readout_sequencer
// Drives fills through fill_readout_sequencer (TIMEOUT shortened to 8) and
// checks header/trailer words, channel order, timeout pulses, handshake
// behaviour and fill latency against a reference model of the fill rules.
module tb_fill_readout_sequencer;

  localparam int NUM_CHAN  = 5;
  localparam int FILLNUM_W = 24;
  localparam int TMO       = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_CHAN-1:0]  chan_enable = '0;
  logic                 fill_valid = 1'b0;
  logic [FILLNUM_W-1:0] fill_num = '0;
  logic                 fill_ready;
  logic                 evt_valid;
  logic [31:0]          evt_data;
  logic                 evt_ready = 1'b1;
  logic                 rd_start;
  logic [2:0]           rd_chan;
  logic                 rd_done = 1'b0;
  logic                 busy;
  logic                 timeout_err;

  int total = 0;
  int bad   = 0;

  // One fill: delay per channel is the WAIT cycle (1-based) in which rd_done
  // is raised, 0 meaning never. mode 0 = evt_ready always high,
  // 1 = ten cycles of backpressure on each word, 2 = random evt_ready and
  // random rd_done noise outside the wait window.
  typedef struct {
    logic [23:0]     fnum;
    logic [4:0]      en;
    logic [4:0][7:0] dly;
    int              mode;
    logic [31:0]     exp_hdr;
    logic [31:0]     exp_trl;
  } vec_t;

  vec_t vecs[8];

  fill_readout_sequencer #(
    .NUM_CHAN (NUM_CHAN),
    .FILLNUM_W(FILLNUM_W),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chan_enable(chan_enable),
    .fill_valid (fill_valid),
    .fill_num   (fill_num),
    .fill_ready (fill_ready),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .rd_start   (rd_start),
    .rd_chan    (rd_chan),
    .rd_done    (rd_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // A channel completes when rd_done arrives within the TIMEOUT wait cycles.
  function automatic bit chan_completes(input logic [7:0] d);
    return (d != 0) && (int'(d) <= TMO);
  endfunction

  function automatic logic [31:0] model_trailer(input logic [4:0] en, input logic [4:0][7:0] dly);
    logic [4:0] rd;
    logic [4:0] tm;
    rd = '0;
    tm = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (en[c]) begin
        if (chan_completes(dly[c])) rd[c] = 1'b1;
        else tm[c] = 1'b1;
      end
    end
    return {8'hF2, 3'b000, tm, 11'b0, rd};
  endfunction

  // Runs one fill cycle by cycle, acting as both FIFO and readout responder,
  // then compares everything observed against the model.
  task automatic applyStimulus(input vec_t v, input string tag);
    int exp_chans[$];
    int exp_tmos[$];
    int got_chans[$];
    int got_tmos[$];
    int exp_cycles;
    logic [31:0] hdr;
    logic [31:0] trl;
    logic [31:0] last_data;
    bit hdr_xfer;
    bit trl_xfer;
    bit prev_hold;
    bit active;
    bit tmo_now;
    bit finished;
    int hold_cnt;
    int wcnt;
    int cur_ch;
    int early;
    int unstable;
    int hs_viol;
    int bad_timing;
    int cycles;
    hdr = '0; trl = '0; last_data = '0;
    hdr_xfer = 0; trl_xfer = 0; prev_hold = 0; active = 0; finished = 0;
    hold_cnt = 0; wcnt = 0; cur_ch = 0; early = 0; unstable = 0;
    hs_viol = 0; bad_timing = 0; cycles = 0;

    exp_cycles = 3;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (v.en[c]) begin
        exp_chans.push_back(c);
        if (chan_completes(v.dly[c])) begin
          exp_cycles += 2 + int'(v.dly[c]);
        end else begin
          exp_tmos.push_back(c);
          exp_cycles += 2 + TMO;
        end
      end
    end

    @(negedge clk);
    checkOutput({tag, "_idle_ready"}, {31'b0, fill_ready}, 32'd1);
    fill_valid  = 1'b1;
    fill_num    = v.fnum;
    chan_enable = v.en;
    rd_done     = 1'b0;
    evt_ready   = (v.mode == 0);
    @(negedge clk);
    fill_valid  = 1'b0;
    fill_num    = 24'($urandom);
    chan_enable = ~v.en;

    while (cycles < 2000) begin
      if (trl_xfer) begin
        checkOutput({tag, "_end_ready"}, {31'b0, fill_ready}, 32'd1);
        checkOutput({tag, "_end_busy"}, {31'b0, busy}, 32'd0);
        finished = 1;
        break;
      end
      cycles++;
      if (!busy || fill_ready) hs_viol++;
      tmo_now = 0;

      if (evt_valid) begin
        if (prev_hold && evt_data !== last_data) unstable++;
        last_data = evt_data;
        if (!hdr_xfer) hdr = evt_data;
        else trl = evt_data;
        if (v.mode == 0) evt_ready = 1'b1;
        else if (v.mode == 1) evt_ready = (hold_cnt >= 10);
        else evt_ready = 1'($urandom_range(0, 1));
        if (evt_ready) begin
          if (!hdr_xfer) hdr_xfer = 1;
          else trl_xfer = 1;
          hold_cnt  = 0;
          prev_hold = 0;
        end else begin
          hold_cnt++;
          prev_hold = 1;
        end
      end else begin
        if (prev_hold) unstable++;
        prev_hold = 0;
        if (v.mode == 0) evt_ready = 1'b1;
        else if (v.mode == 1) evt_ready = 1'b0;
        else evt_ready = 1'($urandom_range(0, 1));
      end

      if (rd_start) begin
        if (!hdr_xfer) early++;
        cur_ch = int'(rd_chan);
        got_chans.push_back(cur_ch);
        active  = 1;
        wcnt    = 0;
        rd_done = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (active) begin
        wcnt++;
        rd_done = (cur_ch < NUM_CHAN) && (int'(v.dly[cur_ch]) == wcnt);
        if (!rd_done && wcnt >= TMO) tmo_now = 1;
        if (rd_done || wcnt >= TMO) active = 0;
      end else begin
        rd_done = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end

      #1;
      if (timeout_err) begin
        got_tmos.push_back(cur_ch);
        if (!tmo_now) bad_timing++;
      end
      @(negedge clk);
    end
    rd_done   = 1'b0;
    evt_ready = 1'b1;

    checkOutput({tag, "_completed"}, {31'b0, finished}, 32'd1);
    checkOutput({tag, "_header"}, hdr, v.exp_hdr);
    checkOutput({tag, "_trailer"}, trl, v.exp_trl);
    checkOutput({tag, "_chan_count"}, got_chans.size(), exp_chans.size());
    for (int i = 0; i < got_chans.size() && i < exp_chans.size(); i++)
      checkOutput($sformatf("%s_chan%0d", tag, i), got_chans[i], exp_chans[i]);
    checkOutput({tag, "_tmo_count"}, got_tmos.size(), exp_tmos.size());
    for (int i = 0; i < got_tmos.size() && i < exp_tmos.size(); i++)
      checkOutput($sformatf("%s_tmo%0d", tag, i), got_tmos[i], exp_tmos[i]);
    checkOutput({tag, "_tmo_timing"}, bad_timing, 0);
    checkOutput({tag, "_early_start"}, early, 0);
    checkOutput({tag, "_evt_stable"}, unstable, 0);
    checkOutput({tag, "_busy_ready"}, hs_viol, 0);
    if (v.mode == 0) checkOutput({tag, "_cycles"}, cycles, exp_cycles);
  endtask

  // Main sequence: reset checks, table vectors, mid-fill reset, random fills.
  initial begin
    vec_t v;
    bit   got;

    vecs[0] = '{24'h000042, 5'b11111, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 0, 32'hF1000042, 32'hF200001F};
    vecs[1] = '{24'h000100, 5'b10100, {8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, 0, 32'hF1000100, 32'hF2000014};
    vecs[2] = '{24'h000200, 5'b00011, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, 0, 32'hF1000200, 32'hF2020001};
    vecs[3] = '{24'h000300, 5'b00001, {8'd0, 8'd0, 8'd0, 8'd0, 8'd8}, 0, 32'hF1000300, 32'hF2000001};
    vecs[4] = '{24'h000400, 5'b00000, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 32'hF1000400, 32'hF2000000};
    vecs[5] = '{24'h000500, 5'b10101, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1, 32'hF1000500, 32'hF2000015};
    vecs[6] = '{24'h000600, 5'b11111, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 0, 32'hF1000600, 32'hF200001F};
    vecs[7] = '{24'h000700, 5'b11111, {8'd9, 8'd0, 8'd3, 8'd8, 8'd1}, 2, 32'hF1000700, 32'hF2180007};

    reset_n   = 1'b0;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_fill_ready", {31'b0, fill_ready}, 32'd1);
    checkOutput("rst_evt_valid", {31'b0, evt_valid}, 32'd0);
    checkOutput("rst_evt_data", evt_data, 32'd0);
    checkOutput("rst_rd_start", {31'b0, rd_start}, 32'd0);
    checkOutput("rst_rd_chan", {29'b0, rd_chan}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Abandon a fill while channel 0 is waiting, then start a clean one.
    @(negedge clk);
    fill_valid  = 1'b1;
    fill_num    = 24'h0000AA;
    chan_enable = 5'b00001;
    rd_done     = 1'b0;
    @(negedge clk);
    fill_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_start) got = 1;
    end
    checkOutput("midrst_start_seen", {31'b0, got}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy_before", {31'b0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midrst_rd_start", {31'b0, rd_start}, 32'd0);
    checkOutput("midrst_evt_valid", {31'b0, evt_valid}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_fill_ready", {31'b0, fill_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_trailer", {31'b0, evt_valid}, 32'd0);
    v = '{24'hFFFFFF, 5'b00110, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 0, 32'hF1FFFFFF, 32'hF2000006};
    applyStimulus(v, "post_reset");

    // Random fills checked against the model.
    for (int n = 0; n < 25; n++) begin
      v.fnum = 24'($urandom);
      v.en   = 5'($urandom);
      for (int c = 0; c < NUM_CHAN; c++) v.dly[c] = 8'($urandom_range(0, 11));
      v.mode    = (n % 4 == 0) ? 0 : 2;
      v.exp_hdr = {8'hF1, v.fnum};
      v.exp_trl = model_trailer(v.en, v.dly);
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fill_readout_sequencer.md
# fill_readout_sequencer

Sequences per-fill channel readout downstream of the trigger manager. It pops one fill number from the trigger manager's fill-number FIFO interface and emits a header word. It then drives each enabled digitizer channel through a start/done readout handshake in ascending channel order, with a per-channel timeout, and closes the fill with a trailer word on the same event-builder port.

## Interface
- NUM_CHAN, 5: number of channels; rd_chan width is 3 bits, so NUM_CHAN ≤ 8.
- FILLNUM_W, 24: fill number width.
- TIMEOUT, 50000: maximum cycles allowed in WAIT per channel; 16-bit counter; legal range 1..65535.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset. Deassertion must be synchronous to clk.
- chan_enable  in  NUM_CHAN  channel mask, captured on fill accept.
- fill_valid  in  1  fill number available.
- fill_num  in  FILLNUM_W  fill number.
- fill_ready  out  1  fill accept (pop).
- evt_valid  out  1  header/trailer word valid.
- evt_data  out  32  header/trailer word.
- evt_ready  in  1  event builder accept.
- rd_start  out  1  one-cycle readout start pulse.
- rd_chan  out  3  channel being read.
- rd_done  in  1  channel readout complete.
- busy  out  1  high whenever state ≠ IDLE.
- timeout_err  out  1  one-cycle pulse on channel timeout.

## Operation
- States: IDLE, HEADER, SCAN, START, WAIT, TRAILER.
- **IDLE:** fill_ready=1.
  - On fill_valid: latch fill_num, latch chan_enable into pend_mask, clear rd_mask/tmo_mask, go to HEADER.
- **HEADER:** evt_valid=1, evt_data={8'hF1, fill_num}.
  - Holds until evt_ready, then goes to SCAN.
- **SCAN:** select the lowest set bit of pend_mask into rd_chan, clear that bit, go to START.
  - If pend_mask=0, go to TRAILER.
- **START:** rd_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
- **WAIT:** counter increments each cycle.
  - rd_done=1: set rd_mask[rd_chan], go to SCAN.
  - Otherwise, when counter reaches TIMEOUT-1: set tmo_mask[rd_chan], pulse timeout_err, go to SCAN.
  - rd_done on the expiry cycle counts as done, with no timeout.
- **TRAILER:** evt_valid=1, evt_data={8'hF2, 3'b0, tmo_mask, 11'b0, rd_mask}, with masks zero-extended to 5 bits.
  - Holds until evt_ready, then goes to IDLE.
- rd_done is ignored outside WAIT.
- evt_data is held stable while evt_valid=1 and evt_ready=0.
- rd_chan holds its value from SCAN until the next SCAN selection.
- chan_enable changes after accept have no effect on the current fill.
- chan_enable=0 at accept: header, then trailer with both masks zero; no rd_start.
- Fill numbers are passed through unmodified. Wrap-around of fill_num is the trigger manager's concern.

## Timing
- Reset (reset_n=0): state=IDLE immediately; latched fill number and masks cleared.
  - Outputs: fill_ready=1; evt_valid=0, evt_data=0, rd_start=0, rd_chan=0, busy=0, timeout_err=0.
- Reset mid-fill: the fill is abandoned with no trailer; the next accepted fill starts clean.
- Accept occurs on the edge where fill_valid & fill_ready. evt_valid rises the following cycle.
- Header transfer occurs on the edge where evt_valid & evt_ready. Then SCAN takes 1 cycle, and rd_start is asserted in the next cycle.
- Minimum per-channel overhead: SCAN + START + 1 WAIT cycle = 3 cycles.
- Timeout: WAIT exits after exactly TIMEOUT cycles without rd_done. timeout_err asserts in the last WAIT cycle.
- Minimum fill with all 5 channels, rd_done in the first WAIT cycle, and evt_ready tied high:
  - 1 (HEADER) + 5×3 + 1 (final SCAN) + 1 (TRAILER) = 18 cycles from accept to return to IDLE.
- fill_ready is low for the whole fill. A back-to-back fill is accepted on the first IDLE cycle.

## Test plan
- **Reset values:** hold reset_n=0, evt_ready=1 → all outputs at reset values, fill_ready=1.
  - Release reset, then fill_valid=1, fill_num=24'h000042, chan_enable=5'b11111 → header 32'hF1000042.
  - rd_start pulses for channels 0..4 in order; rd_done after 2 cycles each.
  - Trailer 32'hF200001F; busy falls.
- **Sparse mask:** chan_enable=5'b10100 → rd_start only for rd_chan=2 then 4.
  - Trailer 32'hF2000014.
- **Timeout:** TIMEOUT=8, chan_enable=5'b00011, channel 1 never asserts rd_done.
  - timeout_err pulses once, 8 cycles after channel 1's rd_start.
  - Trailer 32'hF2020001.
- **Done/timeout collision:** rd_done asserted on the expiry cycle → no timeout_err; rd_mask bit set.
- **Backpressure and empty mask:** evt_ready=0 for 10 cycles during header and trailer → evt_data stable, no rd_start before the header transfer.
  - chan_enable=0 → header then trailer 32'hF2000000.
- **Reset mid-operation:** assert reset_n=0 in WAIT → rd_start=0, evt_valid=0 immediately, no trailer.
  - Next fill 24'hFFFFFF produces header 32'hF1FFFFFF.
